// File: rtl/shift_reg_piso_tx.sv
// Parallel-in / serial-out transmitter: valid/ready word load, one bit per clock on q,
// with q_valid qualifier and a done pulse on the last bit; back-to-back words without gaps.
module shift_reg_piso_tx #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             q,
  output logic             q_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] sreg, sreg_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic             q_nx, q_valid_nx, busy_nx, done_nx;
  logic             accept;

  logic             load_first, shift_bit;
  logic [WIDTH-1:0] load_rest, shift_rest;

  // Bit selection and shift direction follow the transmit order
  always_comb begin
    if (MSB_FIRST) begin
      load_first = data_in[WIDTH-1];
      load_rest  = data_in << 1;
      shift_bit  = sreg[WIDTH-1];
      shift_rest = sreg << 1;
    end else begin
      load_first = data_in[0];
      load_rest  = data_in >> 1;
      shift_bit  = sreg[0];
      shift_rest = sreg >> 1;
    end
  end

  // Ready while idle or while the last bit of the current word is on q
  assign load_ready = reset && ((state == IDLE) || (cnt == '0));
  assign accept     = load_valid && load_ready;

  always_comb begin
    state_nx   = state;
    sreg_nx    = sreg;
    cnt_nx     = cnt;
    q_nx       = 1'b0;
    q_valid_nx = 1'b0;
    busy_nx    = 1'b0;
    done_nx    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nx   = SHIFT;
          q_nx       = load_first;
          sreg_nx    = load_rest;
          cnt_nx     = CNT_LAST;
          q_valid_nx = 1'b1;
          busy_nx    = 1'b1;
        end
      end
      SHIFT: begin
        if (cnt != '0) begin
          q_nx       = shift_bit;
          sreg_nx    = shift_rest;
          cnt_nx     = cnt - CW'(1);
          q_valid_nx = 1'b1;
          busy_nx    = 1'b1;
          done_nx    = (cnt == CW'(1));
        end else if (accept) begin
          q_nx       = load_first;
          sreg_nx    = load_rest;
          cnt_nx     = CNT_LAST;
          q_valid_nx = 1'b1;
          busy_nx    = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      sreg    <= '0;
      cnt     <= '0;
      q       <= 1'b0;
      q_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nx;
      sreg    <= sreg_nx;
      cnt     <= cnt_nx;
      q       <= q_nx;
      q_valid <= q_valid_nx;
      busy    <= busy_nx;
      done    <= done_nx;
    end
  end

endmodule

// File: tb/tb_shift_reg_piso_tx.sv
// Bench for shift_reg_piso_tx: three instances (4-bit MSB, 4-bit LSB, 8-bit MSB) checked
// every cycle against a bit-list model, plus directed stream checks and random traffic.
module tb_shift_reg_piso_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] dv [3];
  logic        lv [3];
  logic        q_o [3], qv_o [3], busy_o [3], done_o [3], rdy_o [3];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  shift_reg_piso_tx #(.WIDTH(4), .MSB_FIRST(1'b1)) u_m4 (
    .clk(clk), .reset(reset), .data_in(dv[0][3:0]), .load_valid(lv[0]), .load_ready(rdy_o[0]),
    .q(q_o[0]), .q_valid(qv_o[0]), .busy(busy_o[0]), .done(done_o[0]));
  shift_reg_piso_tx #(.WIDTH(4), .MSB_FIRST(1'b0)) u_l4 (
    .clk(clk), .reset(reset), .data_in(dv[1][3:0]), .load_valid(lv[1]), .load_ready(rdy_o[1]),
    .q(q_o[1]), .q_valid(qv_o[1]), .busy(busy_o[1]), .done(done_o[1]));
  shift_reg_piso_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) u_m8 (
    .clk(clk), .reset(reset), .data_in(dv[2][7:0]), .load_valid(lv[2]), .load_ready(rdy_o[2]),
    .q(q_o[2]), .q_valid(qv_o[2]), .busy(busy_o[2]), .done(done_o[2]));

  int unsigned wid [3] = '{4, 4, 8};
  bit          msb [3] = '{1'b1, 1'b0, 1'b1};

  // Model: list of the word's bits in send order, index of the bit currently on q
  bit seq [3][32];
  int len [3];
  int pos [3];

  // Observed stream capture for directed checks
  logic [63:0] cap [3];
  int          ndone [3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_ready(input int i);
    return reset && (len[i] == 0 || pos[i] == len[i] - 1);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) begin
        len[i] = 0;
        pos[i] = 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (lv[i] && m_ready(i)) begin
          for (int k = 0; k < int'(wid[i]); k++)
            seq[i][k] = msb[i] ? dv[i][int'(wid[i]) - 1 - k] : dv[i][k];
          len[i] = int'(wid[i]);
          pos[i] = 0;
        end else if (len[i] != 0 && pos[i] < len[i] - 1) begin
          pos[i] = pos[i] + 1;
        end else begin
          len[i] = 0;
          pos[i] = 0;
        end
      end
    end
  end

  // Per-cycle comparison of every instance against the model
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      bit v, b, d;
      v = (len[i] != 0);
      b = v && seq[i][pos[i]];
      d = v && (pos[i] == len[i] - 1);
      check($sformatf("u%0d.q", i),          32'(q_o[i]),    32'(b));
      check($sformatf("u%0d.q_valid", i),    32'(qv_o[i]),   32'(v));
      check($sformatf("u%0d.busy", i),       32'(busy_o[i]), 32'(v));
      check($sformatf("u%0d.done", i),       32'(done_o[i]), 32'(d));
      check($sformatf("u%0d.load_ready", i), 32'(rdy_o[i]),  32'(m_ready(i)));
      if (qv_o[i] === 1'b1) cap[i] = {cap[i][62:0], q_o[i]};
      if (done_o[i] === 1'b1) ndone[i]++;
    end
  end

  task automatic clear_cap();
    for (int i = 0; i < 3; i++) begin
      cap[i]   = '0;
      ndone[i] = 0;
    end
  endtask

  // Present a word and hold it until the block accepts it
  task automatic send(input int i, input logic [31:0] d);
    int t;
    t = 0;
    @(negedge clk); #1;
    dv[i] = d;
    lv[i] = 1'b1;
    while (!m_ready(i) && t < 100) begin
      @(negedge clk); #1;
      t++;
    end
    if (t >= 100) check($sformatf("u%0d.send_timeout", i), 32'd1, 32'd0);
    @(posedge clk); #1;
    lv[i] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      dv[i] = '0;
      lv[i] = 1'b0;
    end
    clear_cap();
    idle(3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst.u%0d.q_valid", i), 32'(qv_o[i]), 32'd0);
      check($sformatf("rst.u%0d.load_ready", i), 32'(rdy_o[i]), 32'd0);
    end
    #1 reset = 1'b1;
    #1 check("rel.load_ready", 32'(rdy_o[0]), 32'd1);

    // Single word from idle in both orders and at WIDTH=8
    clear_cap();
    fork
      send(0, 32'hB);
      send(1, 32'hB);
      send(2, 32'hA5);
    join
    idle(10);
    check("m4.1011",  32'(cap[0][3:0]), 32'hB);
    check("l4.1011",  32'(cap[1][3:0]), 32'hD);
    check("m8.a5",    32'(cap[2][7:0]), 32'hA5);
    check("m4.ndone", 32'(ndone[0]), 32'd1);
    check("m8.ndone", 32'(ndone[2]), 32'd1);

    // Back-to-back words, then a word offered mid-flight
    clear_cap();
    send(0, 32'hC);
    send(0, 32'h5);
    idle(6);
    check("b2b.stream", 32'(cap[0][7:0]), 32'hC5);
    check("b2b.ndone",  32'(ndone[0]), 32'd2);
    clear_cap();
    send(0, 32'h0);
    @(negedge clk); #1;
    check("busy.ready", 32'(rdy_o[0]), 32'd0);
    send(0, 32'hF);
    idle(6);
    check("hold.stream", 32'(cap[0][7:0]), 32'h0F);

    // Asynchronous reset mid-word, then a clean word
    clear_cap();
    send(0, 32'hA);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check("arst.q",          32'(q_o[0]),    32'd0);
    check("arst.q_valid",    32'(qv_o[0]),   32'd0);
    check("arst.busy",       32'(busy_o[0]), 32'd0);
    check("arst.done",       32'(done_o[0]), 32'd0);
    check("arst.load_ready", 32'(rdy_o[0]),  32'd0);
    idle(2);
    #1 reset = 1'b1;
    check("arst.ndone", 32'(ndone[0]), 32'd0);
    clear_cap();
    send(0, 32'h6);
    idle(6);
    check("arst.after", 32'(cap[0][3:0]), 32'h6);
    check("arst.after_ndone", 32'(ndone[0]), 32'd1);

    // Random traffic on all instances, model checks every cycle
    for (int c = 0; c < 400; c++) begin
      @(negedge clk); #1;
      for (int i = 0; i < 3; i++) begin
        if (!lv[i] || m_ready(i)) dv[i] = $urandom;
        lv[i] = ($urandom_range(0, 3) != 0);
      end
      if (c == 200) begin
        #2 reset = 1'b0;
        #2 reset = 1'b1;
      end
    end
    for (int i = 0; i < 3; i++) lv[i] = 1'b0;
    idle(12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_reg_piso_tx.md
# shift_reg_piso_tx

Parallel-in / serial-out transmitter that feeds the serial shift-register chain. Accepts a WIDTH-bit word through a valid/ready load handshake and shifts it onto a single serial line, one bit per clock, with a qualifying `q_valid` strobe and an end-of-word `done` pulse. Supports back-to-back words with no idle gap, so a downstream serial-in register sees a continuous bit stream.

## Interface
- `WIDTH`, default 4: word length in bits; legal range 2..32.
- `MSB_FIRST`, default 1: 1 sends bit WIDTH-1 first, 0 sends bit 0 first.

- `clk`  input  1  rising-edge clock.
- `reset`  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- `data_in`  input  WIDTH  parallel word, sampled only on an accepted load.
- `load_valid`  input  1  producer has a word on `data_in`.
- `load_ready`  output  1  block can accept a word this cycle (combinational).
- `q`  output  1  serial data out (registered).
- `q_valid`  output  1  `q` carries a payload bit this cycle (registered).
- `busy`  output  1  a word is being shifted (registered).
- `done`  output  1  one-cycle pulse coincident with the last bit of a word (registered).

## Operation
- States: IDLE, SHIFT. Internal: shift register `sreg[WIDTH-1:0]`, bit counter `cnt` (ceil(log2(WIDTH)) bits, counts remaining bits after the one on `q`).
- Accept = `load_valid && load_ready` at a rising edge.
- `load_ready` = `reset` && (state==IDLE || (state==SHIFT && cnt==0)).
- IDLE, accept: `q` <= first bit of `data_in` (per MSB_FIRST); `sreg` <= `data_in` shifted by one toward the first-bit end; `cnt` <= WIDTH-1; `q_valid` <= 1; `busy` <= 1; state -> SHIFT.
- IDLE, no accept: `q` <= 0, `q_valid` <= 0, `busy` <= 0, `done` <= 0.
- SHIFT, cnt>0: `q` <= next bit of `sreg`; shift `sreg`; `cnt` <= cnt-1; `done` <= (cnt==1).
- SHIFT, cnt==0 (last bit on `q`), accept: load new word exactly as from IDLE; stay SHIFT; `done` <= 0. No gap between words.
- SHIFT, cnt==0, no accept: state -> IDLE; `q` <= 0, `q_valid` <= 0, `busy` <= 0, `done` <= 0.
- `load_valid` while `load_ready`=0 is ignored; `data_in` is not sampled; the producer holds it.
- `q` is 0 whenever `q_valid` is 0 (line idles low).

## Timing
- Reset (`reset`=0, async): state IDLE, `sreg`=0, `cnt`=0, `q`=0, `q_valid`=0, `busy`=0, `done`=0, `load_ready`=0. After release, `load_ready`=1 the same cycle.
- Reset mid-word: the word is abandoned; outputs clear immediately, no `done`.
- Latency: first bit on `q` right after the accepting edge E; bit k (k=0..WIDTH-1) valid from edge E+k to E+k+1.
- `q_valid` high for exactly WIDTH cycles per word; `done` high only during bit WIDTH-1.
- Throughput: one word per WIDTH cycles sustained when `load_valid` is held high.
- `busy` equals `q_valid`.

## Test plan
- WIDTH=4, MSB_FIRST=1, load 4'b1011 from IDLE -> `q`=1,0,1,1 on four consecutive cycles, `q_valid`=1 for exactly 4 cycles, `done`=1 only on the 4th, then `q`=0, `q_valid`=0.
- MSB_FIRST=0, load 4'b1011 -> `q`=1,1,0,1.
- Back-to-back: `load_valid` held high with 4'b1100 then 4'b0101 presented on the last bit -> `q`=1,1,0,0,0,1,0,1 with `q_valid` continuously 1, `done` pulses on cycles 4 and 8.
- `load_valid`=1 with 4'b1111 during bit 1 of an in-flight 4'b0000 -> `load_ready`=0, ignored; stream stays 0,0,0,0; word accepted only on the last-bit cycle.
- `reset`=0 asynchronously during bit 2 of 4'b1010 -> `q`, `q_valid`, `busy`, `done` go 0 immediately; after release, a new load of 4'b0110 transmits 0,1,1,0 cleanly.
- WIDTH=8, load 8'hA5 -> 1,0,1,0,0,1,0,1, `done` on the 8th bit only.
